// File: rtl/seq_match_sched.sv
// seq_match_sched: one 4-state symbol-sequence detector shared by NCH
// requesters. Round-robin arbitration picks at most one symbol per cycle.
// The granted channel's saved detector state is advanced and written back.
// Entering (or staying in) S3 counts as a match event, which drives a
// registered hit pulse and a saturating per-channel counter.
module seq_match_sched #(
  parameter int NCH   = 4,
  parameter int CNT_W = 8,
  parameter int CW    = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic [NCH-1:0]       req_valid,
  input  logic [2*NCH-1:0]     req_num,
  output logic [NCH-1:0]       req_ready,
  output logic                 hit,
  output logic [CW-1:0]        hit_ch,
  output logic [NCH-1:0]       match,
  input  logic [CW-1:0]        rd_ch,
  output logic [CNT_W-1:0]     rd_cnt
);

  localparam logic [1:0] S0 = 2'b00;
  localparam logic [1:0] S1 = 2'b01;
  localparam logic [1:0] S2 = 2'b10;
  localparam logic [1:0] S3 = 2'b11;

  // Per-channel saved context and match counters
  logic [1:0]       state_reg [NCH];
  logic [CNT_W-1:0] cnt_reg   [NCH];

  logic [CW-1:0]    ptr_reg;
  logic             hit_reg;
  logic [CW-1:0]    hit_ch_reg;

  logic [NCH-1:0]   grant;
  logic [CW-1:0]    gidx;
  logic             xfer;
  logic [1:0]       cur_state;
  logic [1:0]       sym;
  logic [1:0]       state_next;
  logic             match_ev;

  // Round-robin search starting at ptr; clr suppresses every grant so the
  // clearing cycle never carries a transfer. Only valid channels can win,
  // so a grant always implies a transfer.
  always_comb begin
    grant = '0;
    gidx  = '0;
    xfer  = 1'b0;
    if (!clr) begin
      for (int k = 0; k < NCH; k++) begin
        if (!xfer && req_valid[CW'(ptr_reg + CW'(k))]) begin
          xfer = 1'b1;
          gidx = CW'(ptr_reg + CW'(k));
        end
      end
      if (xfer) grant[gidx] = 1'b1;
    end
  end

  assign req_ready = grant;

  // Shared detector next-state function applied to the granted channel only
  always_comb begin
    cur_state  = state_reg[gidx];
    sym        = req_num[{gidx, 1'b0} +: 2];
    state_next = S0;
    case (sym)
      2'b00: state_next = S0;
      2'b01: state_next = S1;
      2'b10: state_next = (cur_state == S1 || cur_state == S2) ? S2 : S0;
      2'b11: state_next = (cur_state == S2 || cur_state == S3) ? S3 : S0;
      default: state_next = S0;
    endcase
    match_ev = xfer && (state_next == S3);
  end

  // Per-channel context and counter registers; only the granted lane updates
  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      logic upd;
      assign upd = xfer && (gidx == CW'(gi));

      // Detector state write-back and saturating match count
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state_reg[gi] <= S0;
          cnt_reg[gi]   <= '0;
        end else if (clr) begin
          state_reg[gi] <= S0;
          cnt_reg[gi]   <= '0;
        end else if (upd) begin
          state_reg[gi] <= state_next;
          if (match_ev && (cnt_reg[gi] != {CNT_W{1'b1}}))
            cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
        end
      end

      assign match[gi] = (state_reg[gi] == S3);
    end
  endgenerate

  // Arbitration pointer and registered hit reporting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg    <= '0;
      hit_reg    <= 1'b0;
      hit_ch_reg <= '0;
    end else if (clr) begin
      ptr_reg    <= '0;
      hit_reg    <= 1'b0;
    end else begin
      hit_reg <= match_ev;
      if (match_ev) hit_ch_reg <= gidx;
      if (xfer)     ptr_reg    <= CW'(gidx + 1'b1);
    end
  end

  assign hit    = hit_reg;
  assign hit_ch = hit_ch_reg;
  assign rd_cnt = cnt_reg[rd_ch];

endmodule

// File: tb/tb_seq_match_sched.sv
// Directed testbench for seq_match_sched (NCH=4, CNT_W=2 so saturation is
// reachable in a few symbols). Inputs change 1 time unit after the rising
// edge; outputs are checked 2 time units after the edge.
module tb_seq_match_sched;

  localparam int NCH   = 4;
  localparam int CNT_W = 2;
  localparam int CW    = 2;

  logic             clk;
  logic             rst_n;
  logic             clr;
  logic [NCH-1:0]   req_valid;
  logic [2*NCH-1:0] req_num;
  logic [NCH-1:0]   req_ready;
  logic             hit;
  logic [CW-1:0]    hit_ch;
  logic [NCH-1:0]   match;
  logic [CW-1:0]    rd_ch;
  logic [CNT_W-1:0] rd_cnt;

  int n_cmp;
  int n_err;

  seq_match_sched #(.NCH(NCH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .req_valid(req_valid),
    .req_num  (req_num),
    .req_ready(req_ready),
    .hit      (hit),
    .hit_ch   (hit_ch),
    .match    (match),
    .rd_ch    (rd_ch),
    .rd_cnt   (rd_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Advance one clock; leave time 1 unit past the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_sym(input int ch, input logic [1:0] s);
    req_num[2*ch +: 2] = s;
  endtask

  // Single-channel transfer: check the grant, then clock it in
  task automatic send(input int ch, input logic [1:0] s, input string tag);
    req_valid = '0;
    req_valid[ch] = 1'b1;
    set_sym(ch, s);
    #1;
    chk({tag, ".ready"}, 32'(req_ready), 32'(1 << ch));
    step();
    req_valid = '0;
    #1;
  endtask

  task automatic do_clr();
    req_valid = '0;
    clr = 1'b1;
    step();
    clr = 1'b0;
    #1;
  endtask

  task automatic chk_all_cnt_zero(input string tag);
    for (int c = 0; c < NCH; c++) begin
      rd_ch = CW'(c);
      #1;
      chk($sformatf("%s.cnt%0d", tag, c), 32'(rd_cnt), 32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] seq2 [3];
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    clr = 1'b0;
    req_valid = '0;
    req_num = '0;
    rd_ch = '0;

    // Reset state
    step();
    step();
    chk("rst.hit", 32'(hit), 32'd0);
    chk("rst.match", 32'(match), 32'd0);
    chk("rst.rd_cnt", 32'(rd_cnt), 32'd0);
    chk("rst.ready", 32'(req_ready), 32'd0);
    rst_n = 1'b1;
    step();

    // T1: channel 0 sends 01,10,11
    send(0, 2'b01, "t1.s01");
    chk("t1.match_a", 32'(match), 32'd0);
    send(0, 2'b10, "t1.s10");
    chk("t1.hit_a", 32'(hit), 32'd0);
    send(0, 2'b11, "t1.s11");
    chk("t1.match", 32'(match), 32'b0001);
    chk("t1.hit", 32'(hit), 32'd1);
    chk("t1.hit_ch", 32'(hit_ch), 32'd0);
    rd_ch = 2'd0;
    #1;
    chk("t1.rd_cnt", 32'(rd_cnt), 32'd1);

    // T2: all valid, round robin; channel 2 sends 01,10,11 on its turns
    do_clr();
    seq2[0] = 2'b01;
    seq2[1] = 2'b10;
    seq2[2] = 2'b11;
    req_valid = 4'b1111;
    req_num = '0;
    for (int c = 0; c < 12; c++) begin
      set_sym(2, seq2[c / 4]);
      #1;
      chk($sformatf("t2.grant%0d", c), 32'(req_ready), 32'(1 << (c % 4)));
      step();
      chk($sformatf("t2.hit%0d", c), 32'(hit), (c == 10) ? 32'd1 : 32'd0);
      if (c == 10) chk("t2.hit_ch", 32'(hit_ch), 32'd2);
    end
    req_valid = '0;
    chk("t2.match", 32'(match), 32'b0100);

    // T3: context isolation between channels 1 and 3
    do_clr();
    send(1, 2'b01, "t3.c1s01");
    send(1, 2'b10, "t3.c1s10");
    send(3, 2'b11, "t3.c3s11");
    chk("t3.c3.hit", 32'(hit), 32'd0);
    chk("t3.c3.match", 32'(match), 32'd0);
    send(1, 2'b11, "t3.c1s11");
    chk("t3.c1.hit", 32'(hit), 32'd1);
    chk("t3.c1.hit_ch", 32'(hit_ch), 32'd1);
    chk("t3.c1.match", 32'(match), 32'b0010);

    // T4: six 11s on channel 0, counter saturates at 3
    do_clr();
    rd_ch = 2'd0;
    send(0, 2'b01, "t4.s01");
    send(0, 2'b10, "t4.s10");
    for (int k = 1; k <= 6; k++) begin
      req_valid = 4'b0001;
      set_sym(0, 2'b11);
      #1;
      chk($sformatf("t4.old%0d", k), 32'(rd_cnt), 32'((k - 1 > 3) ? 3 : k - 1));
      step();
      req_valid = '0;
      chk($sformatf("t4.hit%0d", k), 32'(hit), 32'd1);
      chk($sformatf("t4.cnt%0d", k), 32'(rd_cnt), 32'((k > 3) ? 3 : k));
    end

    // T5: clr while channel 0 presents 11 in S2
    do_clr();
    send(3, 2'b01, "t5.c3s01");
    send(3, 2'b10, "t5.c3s10");
    send(3, 2'b11, "t5.c3s11");
    send(0, 2'b01, "t5.c0s01");
    send(0, 2'b10, "t5.c0s10");
    req_valid = 4'b0101;
    set_sym(0, 2'b11);
    set_sym(2, 2'b00);
    clr = 1'b1;
    #1;
    chk("t5.clr_ready", 32'(req_ready), 32'd0);
    step();
    clr = 1'b0;
    chk("t5.hit", 32'(hit), 32'd0);
    chk("t5.match", 32'(match), 32'd0);
    chk_all_cnt_zero("t5");
    chk("t5.lowest", 32'(req_ready), 32'b0001);
    step();
    req_valid = '0;
    chk("t5.no_hit", 32'(hit), 32'd0);
    chk("t5.c0_s0", 32'(match), 32'd0);

    // T6: asynchronous reset the cycle after a match transfer
    do_clr();
    send(1, 2'b01, "t6.s01");
    send(1, 2'b10, "t6.s10");
    send(1, 2'b11, "t6.s11");
    chk("t6.pre_hit", 32'(hit), 32'd1);
    chk("t6.pre_hit_ch", 32'(hit_ch), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6.hit", 32'(hit), 32'd0);
    chk("t6.hit_ch", 32'(hit_ch), 32'd0);
    chk("t6.match", 32'(match), 32'd0);
    chk_all_cnt_zero("t6");
    step();
    req_valid = 4'b1111;
    req_num = '0;
    rst_n = 1'b1;
    #1;
    chk("t6.first", 32'(req_ready), 32'b0001);
    step();
    chk("t6.second", 32'(req_ready), 32'b0010);
    req_valid = '0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
